exception_handler: RTL and testbench
====================================

Name: exception_handler

Overview:
- M-mode trap sequencer, directly downstream of the shared privileged-architecture package and upstream of the CSR register file and the fetch redirect port.
- Accepts synchronous exceptions from commit, pending interrupts from mip/mie, and MRET requests.
- Selects one event, produces the mepc/mcause/mtval/mstatus write set, and drives a held redirect to the trap vector or to mepc.
- Owns the current privilege level. No delegation: every trap targets M-mode.

Parameters:
MXLEN, 64, register width (from package)
BOOT_PRIV, MACHINE, privilege level after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
exc_valid_i  in  1  synchronous exception at commit
exc_code_i  in  63  synchronous_exception_code_t
exc_pc_i  in  64  PC of faulting instruction
exc_tval_i  in  64  trap value
mret_i  in  1  MRET committing
mip_i  in  64  mip_t
mie_i  in  64  mie_t
mstatus_i  in  64  mstatus_t (mie, mpie, mpp read)
mtvec_i  in  64  mtvec_t
mepc_i  in  64  current mepc
csr_we_o  out  1  one-cycle strobe: write mepc/mcause/mtval
mepc_o, mcause_o, mtval_o  out  64 each  write data
mstatus_we_o  out  1  one-cycle strobe: write mie/mpie/mpp
mstatus_mie_o, mstatus_mpie_o  out  1 each  new values
mstatus_mpp_o  out  2  new value
flush_o  out  1  pipeline flush, one cycle
redirect_valid_o  out  1  redirect request
redirect_pc_o  out  64  redirect target
redirect_ready_i  in  1  fetch accepts redirect
privilege_o  out  2  privilege_level_t
busy_o  out  1  state != IDLE

Behaviour:
- Reset (sync, rst_i high at posedge):
  - State IDLE; privilege_o = BOOT_PRIV.
  - All strobes, data outputs, redirect_valid_o, flush_o and busy_o = 0.
  - Reset mid-operation abandons any pending redirect and drops captured state.
- FSM states: IDLE, TRAP_COMMIT, MRET_COMMIT, REDIRECT.
- Event selection, sampled only in IDLE:
  - Priority: exception > interrupt > mret.
  - Inputs arriving in any other state are ignored and dropped; upstream is flushed at that point.
- Interrupt enable: irq_en = (privilege_o < MACHINE) | mstatus_i.mie.
- Pending set: mip_i & mie_i & irq_en.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5) > LCOFI(13). Non-standard bits 63:16 are ignored.
- Interrupt epc: the handler is idle at an instruction boundary, so epc = exc_pc_i. Commit must present the next PC on exc_pc_i whenever valid is low.
- IDLE -> TRAP_COMMIT, registering:
  - cause = {interrupt, code}
  - epc = {pc[63:2], 2'b00}
  - tval = exc_tval_i for exceptions, 0 for interrupts
  - prev_priv = privilege_o
- TRAP_COMMIT (1 cycle):
  - csr_we_o = 1, flush_o = 1.
  - mepc_o = epc, mcause_o = cause, mtval_o = tval.
  - mstatus_we_o = 1: mpie <= mstatus.mie, mie <= 0, mpp <= prev_priv.
  - privilege <= MACHINE.
  - target = {base, 2'b00} for DIRECT or any exception.
  - target = {base, 2'b00} + 4*code for VECTORED interrupts, 64-bit wrap.
  - mtvec mode 2/3 is treated as DIRECT.
  - Next state: REDIRECT.
- IDLE -> MRET_COMMIT when mret_i is high, no exception, and no enabled interrupt.
- MRET_COMMIT (1 cycle):
  - flush_o = 1; mstatus_we_o = 1.
  - mie <= mpie, mpie <= 1, mpp <= USER.
  - privilege <= mstatus.mpp; RESERVED (2'b10) maps to USER.
  - target = {mepc_i[63:2], 2'b00}.
  - Next state: REDIRECT.
- REDIRECT:
  - redirect_valid_o = 1 with redirect_pc_o = target, both held stable until redirect_ready_i.
  - Handshake at posedge with valid & ready -> IDLE.
  - Back-to-back is legal: a new event can be sampled the cycle after return to IDLE.
- Latency: event at cycle N, commit strobes at N+1, redirect_valid_o from N+2. Minimum 3 cycles event-to-IDLE.
- Outputs are registered.

Decomposition:
- Package additions:
  - exc_fsm_state_t
  - interrupt priority order constant
  - mstatus field update struct
  - function vector_target(mtvec_t, code, is_irq)
- Sub-module: irq_priority_encoder (combinational, mip/mie/enable -> valid + asynchronous_exception_code_t).
- FSM, capture registers and privilege register stay in exception_handler.

Test Plan:
- Illegal instruction:
  - Stimulus: priv=USER; exc_valid_i, code=2, pc=0x8000_0102, tval=0xDEAD; ready held high.
  - Response, N+1: mepc_o=0x8000_0100, mcause_o=0x2, mtval_o=0xDEAD, mpp=00, mie=0.
  - Response, N+2: redirect_pc_o = mtvec base<<2.
  - Response: privilege_o=MACHINE.
- Vectored MTI:
  - Stimulus: mtvec=0x1001 (base 0x400, VECTORED); mip.mtip=mie.mtie=1; mstatus.mie=1; priv=MACHINE.
  - Response: mcause_o=0x8000_0000_0000_0007, mtval_o=0, redirect_pc_o=0x101C.
- Priority:
  - Stimulus: MEI, MTI and an exception (code 5) in the same cycle -> exception taken, mcause_o=5.
  - Stimulus: next event with MEI and MTI only -> mcause_o=0x8000_0000_0000_000B.
- Masking: MTI pending, priv=MACHINE, mstatus.mie=0 -> no trap, busy_o stays 0.
- MRET:
  - Stimulus: mepc_i=0x2002, mpp=01, mpie=1.
  - Response: mie=1, mpie=1, mpp=00, privilege_o=SUPERVISOR, redirect_pc_o=0x2000.
- Handshake and reset:
  - Stimulus: ready low for 5 cycles -> redirect_valid_o and redirect_pc_o stable, exc_valid_i pulses dropped.
  - Stimulus: rst_i asserted in REDIRECT -> next cycle all outputs 0, privilege_o=MACHINE.

Source files
------------

// File: rtl/exception_handler_pkg.sv
// Shared types and helpers for the M-mode trap sequencer: privilege levels,
// CSR views, FSM encoding, interrupt priority order and trap-vector arithmetic.
package exception_handler_pkg;

  localparam int unsigned MXLEN     = 64;
  localparam int unsigned IRQ_COUNT = 7;

  typedef enum logic [1:0] {
    USER       = 2'b00,
    SUPERVISOR = 2'b01,
    RESERVED   = 2'b10,
    MACHINE    = 2'b11
  } privilege_level_t;

  typedef logic [MXLEN-2:0] synchronous_exception_code_t;
  typedef logic [MXLEN-2:0] asynchronous_exception_code_t;
  typedef logic [MXLEN-1:0] mip_t;
  typedef logic [MXLEN-1:0] mie_t;

  typedef struct packed {
    logic        sd;
    logic [49:0] rsv_62_13;
    logic [1:0]  mpp;
    logic [1:0]  rsv_10_9;
    logic        spp;
    logic        mpie;
    logic        ube;
    logic        spie;
    logic        rsv_4;
    logic        mie;
    logic        rsv_2;
    logic        sie;
    logic        rsv_0;
  } mstatus_t;

  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  typedef struct packed {
    logic [MXLEN-3:0] base;
    logic [1:0]       mode;
  } mtvec_t;

  typedef struct packed {
    logic             mie;
    logic             mpie;
    privilege_level_t mpp;
  } mstatus_upd_t;

  typedef enum logic [1:0] {
    EXC_IDLE        = 2'd0,
    EXC_TRAP_COMMIT = 2'd1,
    EXC_MRET_COMMIT = 2'd2,
    EXC_REDIRECT    = 2'd3
  } exc_fsm_state_t;

  // Index 0 is the highest priority: MEI, MSI, MTI, SEI, SSI, STI, LCOFI.
  localparam logic [IRQ_COUNT-1:0][5:0] IRQ_PRIO =
    {6'd13, 6'd5, 6'd1, 6'd9, 6'd7, 6'd3, 6'd11};

  // Modes 2 and 3 fall through to the direct base; wrap-around is intentional.
  function automatic logic [MXLEN-1:0] vector_target(input mtvec_t mtvec,
                                                     input logic [MXLEN-2:0] code,
                                                     input logic is_irq);
    logic [MXLEN-1:0] base;
    base = {mtvec.base, 2'b00};
    if (is_irq && (mtvec.mode == MTVEC_VECTORED)) begin
      vector_target = base + {code[MXLEN-3:0], 2'b00};
    end else begin
      vector_target = base;
    end
  endfunction

endpackage

// File: rtl/exception_handler_if.sv
// Bus bundle between commit/CSR/fetch and the trap sequencer.
interface exception_handler_if;
  import exception_handler_pkg::*;

  logic                        exc_valid_i;
  synchronous_exception_code_t exc_code_i;
  logic [MXLEN-1:0]            exc_pc_i;
  logic [MXLEN-1:0]            exc_tval_i;
  logic                        mret_i;
  mip_t                        mip_i;
  mie_t                        mie_i;
  mstatus_t                    mstatus_i;
  mtvec_t                      mtvec_i;
  logic [MXLEN-1:0]            mepc_i;
  logic                        csr_we_o;
  logic [MXLEN-1:0]            mepc_o;
  logic [MXLEN-1:0]            mcause_o;
  logic [MXLEN-1:0]            mtval_o;
  logic                        mstatus_we_o;
  logic                        mstatus_mie_o;
  logic                        mstatus_mpie_o;
  logic [1:0]                  mstatus_mpp_o;
  logic                        flush_o;
  logic                        redirect_valid_o;
  logic [MXLEN-1:0]            redirect_pc_o;
  logic                        redirect_ready_i;
  privilege_level_t            privilege_o;
  logic                        busy_o;

  modport slave (
    input  exc_valid_i, exc_code_i, exc_pc_i, exc_tval_i, mret_i,
           mip_i, mie_i, mstatus_i, mtvec_i, mepc_i, redirect_ready_i,
    output csr_we_o, mepc_o, mcause_o, mtval_o, mstatus_we_o,
           mstatus_mie_o, mstatus_mpie_o, mstatus_mpp_o, flush_o,
           redirect_valid_o, redirect_pc_o, privilege_o, busy_o
  );

  modport master (
    output exc_valid_i, exc_code_i, exc_pc_i, exc_tval_i, mret_i,
           mip_i, mie_i, mstatus_i, mtvec_i, mepc_i, redirect_ready_i,
    input  csr_we_o, mepc_o, mcause_o, mtval_o, mstatus_we_o,
           mstatus_mie_o, mstatus_mpie_o, mstatus_mpp_o, flush_o,
           redirect_valid_o, redirect_pc_o, privilege_o, busy_o
  );
endinterface

// File: rtl/exception_handler_irq_priority_encoder.sv
// Picks the highest-priority pending and enabled M-mode interrupt.
// Only the seven standard interrupt bits take part; all others are ignored.
module irq_priority_encoder
  import exception_handler_pkg::*;
(
  input  mip_t                         mip_i,
  input  mie_t                         mie_i,
  input  logic                         enable_i,
  output logic                         valid_o,
  output asynchronous_exception_code_t code_o
);

  logic [MXLEN-1:0] pending_s;
  logic             unused_s;

  assign unused_s = ^pending_s;

  // Lowest priority applied first so higher-priority hits overwrite it
  always_comb begin
    pending_s = mip_i & mie_i & {MXLEN{enable_i}};
    code_o    = '0;
    code_o    = pending_s[IRQ_PRIO[3'd6]] ? {57'd0, IRQ_PRIO[3'd6]} : code_o;
    code_o    = pending_s[IRQ_PRIO[3'd5]] ? {57'd0, IRQ_PRIO[3'd5]} : code_o;
    code_o    = pending_s[IRQ_PRIO[3'd4]] ? {57'd0, IRQ_PRIO[3'd4]} : code_o;
    code_o    = pending_s[IRQ_PRIO[3'd3]] ? {57'd0, IRQ_PRIO[3'd3]} : code_o;
    code_o    = pending_s[IRQ_PRIO[3'd2]] ? {57'd0, IRQ_PRIO[3'd2]} : code_o;
    code_o    = pending_s[IRQ_PRIO[3'd1]] ? {57'd0, IRQ_PRIO[3'd1]} : code_o;
    code_o    = pending_s[IRQ_PRIO[3'd0]] ? {57'd0, IRQ_PRIO[3'd0]} : code_o;
    valid_o   = |{pending_s[IRQ_PRIO[3'd0]], pending_s[IRQ_PRIO[3'd1]],
                  pending_s[IRQ_PRIO[3'd2]], pending_s[IRQ_PRIO[3'd3]],
                  pending_s[IRQ_PRIO[3'd4]], pending_s[IRQ_PRIO[3'd5]],
                  pending_s[IRQ_PRIO[3'd6]]};
  end

endmodule

// File: rtl/exception_handler.sv
// M-mode trap sequencer: selects exception/interrupt/MRET in IDLE, emits the
// CSR write set for one cycle, then holds a fetch redirect until accepted.
module exception_handler
  import exception_handler_pkg::*;
#(
  parameter privilege_level_t BOOT_PRIV = MACHINE
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  exception_handler_if.slave     bus
);

  exc_fsm_state_t               state_q, state_d;
  privilege_level_t             priv_q, priv_d;
  privilege_level_t             new_priv_q, new_priv_d;
  logic                         csr_we_q, csr_we_d;
  logic [MXLEN-1:0]             mepc_q, mepc_d;
  logic [MXLEN-1:0]             mcause_q, mcause_d;
  logic [MXLEN-1:0]             mtval_q, mtval_d;
  logic                         mstatus_we_q, mstatus_we_d;
  mstatus_upd_t                 mstatus_upd_q, mstatus_upd_d;
  logic                         flush_q, flush_d;
  logic                         redirect_valid_q, redirect_valid_d;
  logic [MXLEN-1:0]             redirect_pc_q, redirect_pc_d;
  logic                         busy_q, busy_d;

  logic                         irq_en_s;
  logic                         irq_valid_s;
  asynchronous_exception_code_t irq_code_s;
  logic                         trap_s;
  logic [MXLEN-2:0]             trap_code_s;
  logic                         unused_s;

  assign irq_en_s = (priv_q < MACHINE) | bus.mstatus_i.mie;
  assign unused_s = ^{bus.mstatus_i, bus.exc_pc_i[1:0], bus.mepc_i[1:0]};

  irq_priority_encoder u_irq_enc (
    .mip_i    (bus.mip_i),
    .mie_i    (bus.mie_i),
    .enable_i (irq_en_s),
    .valid_o  (irq_valid_s),
    .code_o   (irq_code_s)
  );

  // Event selection, commit write set and redirect sequencing
  always_comb begin
    state_d          = state_q;
    priv_d           = priv_q;
    new_priv_d       = new_priv_q;
    csr_we_d         = 1'b0;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    mstatus_we_d     = 1'b0;
    mstatus_upd_d    = mstatus_upd_q;
    flush_d          = 1'b0;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    trap_s           = bus.exc_valid_i | irq_valid_s;
    trap_code_s      = bus.exc_valid_i ? bus.exc_code_i : irq_code_s;

    case (state_q)
      EXC_IDLE: begin
        if (trap_s) begin
          state_d            = EXC_TRAP_COMMIT;
          csr_we_d           = 1'b1;
          mstatus_we_d       = 1'b1;
          flush_d            = 1'b1;
          mepc_d             = {bus.exc_pc_i[MXLEN-1:2], 2'b00};
          mcause_d           = {~bus.exc_valid_i, trap_code_s};
          mtval_d            = bus.exc_valid_i ? bus.exc_tval_i : {MXLEN{1'b0}};
          mstatus_upd_d.mpie = bus.mstatus_i.mie;
          mstatus_upd_d.mie  = 1'b0;
          mstatus_upd_d.mpp  = priv_q;
          new_priv_d         = MACHINE;
        end else if (bus.mret_i) begin
          state_d            = EXC_MRET_COMMIT;
          mstatus_we_d       = 1'b1;
          flush_d            = 1'b1;
          mstatus_upd_d.mie  = bus.mstatus_i.mpie;
          mstatus_upd_d.mpie = 1'b1;
          mstatus_upd_d.mpp  = USER;
          // RESERVED is not a legal return privilege; fall back to USER.
          new_priv_d         = (bus.mstatus_i.mpp == 2'b10) ? USER
                                                            : privilege_level_t'(bus.mstatus_i.mpp);
        end else begin
          state_d = EXC_IDLE;
        end
      end
      EXC_TRAP_COMMIT: begin
        state_d          = EXC_REDIRECT;
        priv_d           = new_priv_q;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = vector_target(bus.mtvec_i, mcause_q[MXLEN-2:0], mcause_q[MXLEN-1]);
      end
      EXC_MRET_COMMIT: begin
        state_d          = EXC_REDIRECT;
        priv_d           = new_priv_q;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = {bus.mepc_i[MXLEN-1:2], 2'b00};
      end
      EXC_REDIRECT: begin
        if (bus.redirect_ready_i) begin
          state_d          = EXC_IDLE;
          redirect_valid_d = 1'b0;
        end else begin
          state_d = EXC_REDIRECT;
        end
      end
      default: begin
        state_d          = EXC_IDLE;
        redirect_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != EXC_IDLE);
  end

  // State, capture and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= EXC_IDLE;
      priv_q           <= BOOT_PRIV;
      new_priv_q       <= BOOT_PRIV;
      csr_we_q         <= 1'b0;
      mepc_q           <= {MXLEN{1'b0}};
      mcause_q         <= {MXLEN{1'b0}};
      mtval_q          <= {MXLEN{1'b0}};
      mstatus_we_q     <= 1'b0;
      mstatus_upd_q    <= '{mie: 1'b0, mpie: 1'b0, mpp: USER};
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= {MXLEN{1'b0}};
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      priv_q           <= priv_d;
      new_priv_q       <= new_priv_d;
      csr_we_q         <= csr_we_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      mstatus_we_q     <= mstatus_we_d;
      mstatus_upd_q    <= mstatus_upd_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  assign bus.csr_we_o         = csr_we_q;
  assign bus.mepc_o           = mepc_q;
  assign bus.mcause_o         = mcause_q;
  assign bus.mtval_o          = mtval_q;
  assign bus.mstatus_we_o     = mstatus_we_q;
  assign bus.mstatus_mie_o    = mstatus_upd_q.mie;
  assign bus.mstatus_mpie_o   = mstatus_upd_q.mpie;
  assign bus.mstatus_mpp_o    = mstatus_upd_q.mpp;
  assign bus.flush_o          = flush_q;
  assign bus.redirect_valid_o = redirect_valid_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.privilege_o      = priv_q;
  assign bus.busy_o           = busy_q;

endmodule

// File: tb/tb_exception_handler.sv
// Directed plus randomized bench for exception_handler against a trap-rule
// reference model kept in the bench.
module tb_exception_handler;
  import exception_handler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exception_handler_if intf ();

  exception_handler #(.BOOT_PRIV(MACHINE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (intf.slave)
  );

  int checks = 0;
  int errors = 0;
  int priv_m = 3;
  logic [63:0] obs_mepc, obs_mcause, obs_mtval, obs_rpc;
  logic        obs_mie, obs_mpie;
  logic [1:0]  obs_mpp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_events();
    intf.exc_valid_i = 1'b0;
    intf.mret_i      = 1'b0;
    intf.mip_i       = 64'd0;
  endtask

  // Drive one event in IDLE and follow it through commit, redirect and handshake.
  task automatic run_event(input string tag, input logic ev, input logic [62:0] code,
                           input logic [63:0] pc, input logic [63:0] tval, input logic mr,
                           input logic [63:0] ip, input logic [63:0] ie,
                           input logic st_mie, input logic st_mpie, input logic [1:0] st_mpp,
                           input logic [63:0] tvec, input logic [63:0] epc_in, input int wait_cycles);
    int prio[7] = '{11, 3, 7, 9, 1, 5, 13};
    logic [63:0] pend, e_cause, e_epc, e_tval, e_tgt, ms_raw, held;
    logic e_mie, e_mpie;
    logic [1:0] e_mpp;
    int kind, irq, e_priv;

    pend = ip & ie;
    if (!(priv_m < 3 || st_mie)) pend = 64'd0;
    irq = -1;
    foreach (prio[k]) if (irq < 0 && pend[prio[k]]) irq = prio[k];
    kind = 0; e_cause = 64'd0; e_tval = 64'd0; e_epc = 64'd0; e_tgt = 64'd0;
    e_mie = 1'b0; e_mpie = 1'b0; e_mpp = 2'd0; e_priv = priv_m;
    if (ev) begin
      kind = 1; e_cause = {1'b0, code}; e_tval = tval;
    end else if (irq >= 0) begin
      kind = 1; e_cause = (64'd1 << 63) | 64'(irq); e_tval = 64'd0;
    end else if (mr) begin
      kind = 2;
    end
    if (kind == 1) begin
      e_epc = pc & ~64'd3; e_mpie = st_mie; e_mie = 1'b0; e_mpp = 2'(priv_m); e_priv = 3;
      e_tgt = tvec & ~64'd3;
      if (!ev && tvec[1:0] == 2'd1) e_tgt = e_tgt + 64'(irq) * 64'd4;
    end else if (kind == 2) begin
      e_mie = st_mpie; e_mpie = 1'b1; e_mpp = 2'd0;
      e_priv = (st_mpp == 2'd2) ? 0 : int'(st_mpp);
      e_tgt = epc_in & ~64'd3;
    end

    ms_raw = {$urandom, $urandom};
    ms_raw[3] = st_mie; ms_raw[7] = st_mpie; ms_raw[12:11] = st_mpp;
    @(negedge clk);
    intf.exc_valid_i = ev; intf.exc_code_i = code; intf.exc_pc_i = pc; intf.exc_tval_i = tval;
    intf.mret_i = mr; intf.mip_i = ip; intf.mie_i = ie; intf.mstatus_i = ms_raw;
    intf.mtvec_i = tvec; intf.mepc_i = epc_in;
    @(negedge clk);
    clear_events();
    if (kind == 0) begin
      chk({tag, "_idle_busy"}, 64'(intf.busy_o), 64'd0);
      chk({tag, "_idle_flush"}, 64'(intf.flush_o), 64'd0);
      chk({tag, "_idle_priv"}, 64'(intf.privilege_o), 64'(priv_m));
      return;
    end
    chk({tag, "_csr_we"}, 64'(intf.csr_we_o), 64'(kind == 1));
    chk({tag, "_flush"}, 64'(intf.flush_o), 64'd1);
    chk({tag, "_mst_we"}, 64'(intf.mstatus_we_o), 64'd1);
    chk({tag, "_busy"}, 64'(intf.busy_o), 64'd1);
    if (kind == 1) begin
      chk({tag, "_mepc"}, intf.mepc_o, e_epc);
      chk({tag, "_mcause"}, intf.mcause_o, e_cause);
      chk({tag, "_mtval"}, intf.mtval_o, e_tval);
    end
    chk({tag, "_mst_mie"}, 64'(intf.mstatus_mie_o), 64'(e_mie));
    chk({tag, "_mst_mpie"}, 64'(intf.mstatus_mpie_o), 64'(e_mpie));
    chk({tag, "_mst_mpp"}, 64'(intf.mstatus_mpp_o), 64'(e_mpp));
    obs_mepc = intf.mepc_o; obs_mcause = intf.mcause_o; obs_mtval = intf.mtval_o;
    obs_mie = intf.mstatus_mie_o; obs_mpie = intf.mstatus_mpie_o; obs_mpp = intf.mstatus_mpp_o;
    @(negedge clk);
    chk({tag, "_rvalid"}, 64'(intf.redirect_valid_o), 64'd1);
    chk({tag, "_rpc"}, intf.redirect_pc_o, e_tgt);
    chk({tag, "_priv"}, 64'(intf.privilege_o), 64'(e_priv));
    chk({tag, "_strobe_off"}, 64'({intf.csr_we_o, intf.mstatus_we_o, intf.flush_o}), 64'd0);
    obs_rpc = intf.redirect_pc_o;
    held = intf.redirect_pc_o;
    for (int w = 0; w < wait_cycles; w++) begin
      intf.exc_valid_i = 1'($urandom_range(0, 1));
      intf.exc_code_i = 63'd4;
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(intf.redirect_valid_o), 64'd1);
      chk({tag, "_hold_pc"}, intf.redirect_pc_o, held);
      chk({tag, "_hold_csr_we"}, 64'(intf.csr_we_o), 64'd0);
    end
    intf.exc_valid_i = 1'b0;
    intf.redirect_ready_i = 1'b1;
    @(negedge clk);
    intf.redirect_ready_i = 1'b0;
    chk({tag, "_done_valid"}, 64'(intf.redirect_valid_o), 64'd0);
    chk({tag, "_done_busy"}, 64'(intf.busy_o), 64'd0);
    priv_m = e_priv;
  endtask

  initial begin
    rst = 1'b1;
    clear_events();
    intf.exc_code_i = 63'd0; intf.exc_pc_i = 64'd0; intf.exc_tval_i = 64'd0;
    intf.mie_i = 64'd0; intf.mstatus_i = 64'd0; intf.mtvec_i = 64'd0; intf.mepc_i = 64'd0;
    intf.redirect_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_priv", 64'(intf.privilege_o), 64'd3);
    chk("rst_outs", 64'({intf.csr_we_o, intf.mstatus_we_o, intf.flush_o,
                         intf.redirect_valid_o, intf.busy_o}), 64'd0);
    chk("rst_rpc", intf.redirect_pc_o, 64'd0);
    rst = 1'b0;
    priv_m = 3;

    // Vectored MTI in M-mode
    run_event("mti", 1'b0, 63'd0, 64'h3000, 64'h55, 1'b0, 64'h80, 64'h80,
              1'b1, 1'b0, 2'd3, 64'h1001, 64'h0, 1);
    chk("mti_cause_const", obs_mcause, 64'h8000_0000_0000_0007);
    chk("mti_tval_const", obs_mtval, 64'd0);
    chk("mti_rpc_const", obs_rpc, 64'h101C);

    // Exception beats interrupts, then MEI beats MTI
    run_event("prio_exc", 1'b1, 63'd5, 64'h4444, 64'h9, 1'b0, 64'h880, 64'h880,
              1'b1, 1'b0, 2'd3, 64'h1001, 64'h0, 0);
    chk("prio_exc_const", obs_mcause, 64'd5);
    run_event("prio_mei", 1'b0, 63'd0, 64'h4448, 64'h0, 1'b0, 64'h880, 64'h880,
              1'b1, 1'b0, 2'd3, 64'h1001, 64'h0, 0);
    chk("prio_mei_const", obs_mcause, 64'h8000_0000_0000_000B);

    // Masked MTI in M-mode with mstatus.mie clear
    run_event("mask", 1'b0, 63'd0, 64'h5000, 64'h0, 1'b0, 64'h80, 64'h80,
              1'b0, 1'b0, 2'd3, 64'h1001, 64'h0, 0);
    @(negedge clk);
    chk("mask_busy2", 64'(intf.busy_o), 64'd0);

    // MRET to S-mode, then to U-mode
    run_event("mret_s", 1'b0, 63'd0, 64'h0, 64'h0, 1'b1, 64'h0, 64'h0,
              1'b0, 1'b1, 2'b01, 64'h1000, 64'h2002, 0);
    chk("mret_s_rpc_const", obs_rpc, 64'h2000);
    chk("mret_s_mst_const", 64'({obs_mie, obs_mpie, obs_mpp}), 64'b1100);
    chk("mret_s_priv_const", 64'(intf.privilege_o), 64'd1);
    run_event("mret_u", 1'b0, 63'd0, 64'h0, 64'h0, 1'b1, 64'h0, 64'h0,
              1'b0, 1'b1, 2'b00, 64'h1000, 64'h8000_0104, 0);

    // Illegal instruction from U-mode
    run_event("ill", 1'b1, 63'd2, 64'h8000_0102, 64'hDEAD, 1'b0, 64'h0, 64'h0,
              1'b0, 1'b0, 2'd0, 64'h4000, 64'h0, 0);
    chk("ill_mepc_const", obs_mepc, 64'h8000_0100);
    chk("ill_mcause_const", obs_mcause, 64'h2);
    chk("ill_mtval_const", obs_mtval, 64'hDEAD);
    chk("ill_mpp_mie_const", 64'({obs_mpp, obs_mie}), 64'd0);
    chk("ill_rpc_const", obs_rpc, 64'h4000);
    chk("ill_priv_const", 64'(intf.privilege_o), 64'd3);

    // Long handshake stall with ignored exception pulses
    run_event("stall", 1'b1, 63'd7, 64'h6000, 64'h1, 1'b0, 64'h0, 64'h0,
              1'b1, 1'b1, 2'd3, 64'h8000, 64'h0, 5);

    // Reset while a redirect is pending
    @(negedge clk);
    intf.exc_valid_i = 1'b1; intf.exc_code_i = 63'd2; intf.exc_pc_i = 64'h7000;
    intf.exc_tval_i = 64'h77; intf.mtvec_i = 64'h9000;
    @(negedge clk);
    clear_events();
    @(negedge clk);
    chk("rstmid_rvalid", 64'(intf.redirect_valid_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_outs", 64'({intf.csr_we_o, intf.mstatus_we_o, intf.flush_o, intf.redirect_valid_o,
                            intf.busy_o, intf.mstatus_mie_o, intf.mstatus_mpie_o, intf.mstatus_mpp_o}), 64'd0);
    chk("rstmid_data", intf.mepc_o | intf.mcause_o | intf.mtval_o | intf.redirect_pc_o, 64'd0);
    chk("rstmid_priv", 64'(intf.privilege_o), 64'd3);
    priv_m = 3;
    @(negedge clk);
    chk("rstmid_idle", 64'(intf.busy_o), 64'd0);

    // Randomized events against the model
    for (int n = 0; n < 60; n++) begin
      logic [63:0] rip, rie;
      rip = {$urandom, $urandom};
      rie = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
      run_event("rnd", 1'($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0) ? {31'($urandom), $urandom} : 63'($urandom_range(0, 15)),
                {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                rip, rie, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
